// File: rtl/mc_boot_loader_if.sv
// mc_boot_loader_if: byte-stream input and memory write port of the boot loader.
interface mc_boot_loader_if #(parameter int ADDR_W = 7);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    modport master(output in_valid, in_byte, input in_ready, mem_we, mem_addr, mem_wdata);
    modport slave(input in_valid, in_byte, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/mc_boot_loader.sv
// mc_boot_loader: streams a length-prefixed image into memory, then releases the CPU reset.
// Optional trailing checksum byte when BOOT_CHECKSUM_EN is defined.
module mc_boot_loader #(parameter int ADDR_W = 7) (
    input  logic             clk,
    input  logic             rstn,
    mc_boot_loader_if.slave  bus,
    output logic             cpu_rstn,
    output logic             done,
    output logic             error
);
    typedef enum logic [2:0] {HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;
`ifdef BOOT_CHECKSUM_EN
    localparam state_t FIN = CHK;
`else
    localparam state_t FIN = DONE;
`endif
    state_t            state, state_nx;
    logic [7:0]        hdr_msb;
    logic [15:0]       n;
    logic [15:0]       hdr_n;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [23:0]       asm_reg;
    logic              acc, last_word;
    assign bus.in_ready = state inside {HDR0, HDR1, DATA, CHK};
    assign acc          = bus.in_valid && bus.in_ready;
    assign hdr_n        = {hdr_msb, bus.in_byte};
    assign last_word    = 16'(word_cnt) == n - 16'd1;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) sum <= '0;
        else if (acc && state == DATA) sum <= sum + bus.in_byte;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            HDR0: if (acc) state_nx = HDR1;
            HDR1: if (acc) state_nx = (hdr_n == 16'd0) ? FIN : ({1'b0, hdr_n} > DEPTH) ? ERR : DATA;
            DATA: if (acc && byte_cnt == 2'd3 && last_word) state_nx = FIN;
`ifdef BOOT_CHECKSUM_EN
            CHK:  if (acc) state_nx = (bus.in_byte == sum) ? DONE : ERR;
`endif
            default: state_nx = state;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= HDR0;
            hdr_msb       <= '0;
            n             <= '0;
            byte_cnt      <= '0;
            word_cnt      <= '0;
            asm_reg       <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_rstn      <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state      <= state_nx;
            bus.mem_we <= 1'b0;
            done       <= state_nx == DONE;
            error      <= state_nx == ERR;
            cpu_rstn   <= state == DONE;
            if (acc && state == HDR0) hdr_msb <= bus.in_byte;
            if (acc && state == HDR1) n <= hdr_n;
            if (acc && state == DATA) begin
                asm_reg  <= {asm_reg[15:0], bus.in_byte};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= word_cnt[ADDR_W-1:0];
                    bus.mem_wdata <= {asm_reg, bus.in_byte};
                    word_cnt      <= word_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mc_boot_loader.sv
// tb_mc_boot_loader: randomized image loads checked against a byte-level model of the stream format.
module tb_mc_boot_loader;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 1 << ADDR_W;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic cpu_rstn, done, error;
    int checks = 0;
    int errors = 0;
    logic [7:0]        img[$];
    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];
    mc_boot_loader_if #(.ADDR_W(ADDR_W)) bus();
    mc_boot_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rstn(rstn), .bus(bus), .cpu_rstn(cpu_rstn), .done(done), .error(error));
    always #5 clk = ~clk;
    always @(negedge clk)
        if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
        end
    task automatic send(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask
    task automatic check_reset_values(input string name);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0 ||
            cpu_rstn !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL %s: got ready=%b we=%b addr=%0h wdata=%h cpu_rstn=%b done=%b error=%b, want 1 0 0 0 0 0 0",
                     name, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rstn, done, error);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask
    task automatic seal();
`ifdef BOOT_CHECKSUM_EN
        logic [7:0] s = 8'h00;
        for (int i = 2; i < img.size(); i++) s += img[i];
        img.push_back(s);
`endif
    endtask
    task automatic run_case(input string name, input int max_gap);
        int n, used, nw;
        bit exp_err;
        logic [7:0] s;
        n = int'({img[0], img[1]});
        exp_err = n > DEPTH;
        nw = exp_err ? 0 : n;
        used = exp_err ? 2 : 2 + 4 * n;
        s = 8'h00;
        for (int i = 2; i < used; i++) s += img[i];
`ifdef BOOT_CHECKSUM_EN
        if (!exp_err) begin
            used++;
            exp_err = img[used-1] !== s;
        end
`endif
        wa.delete();
        wd.delete();
        for (int i = 0; i < img.size(); i++) begin
            if (i > 0 && max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            checks++;
            if (bus.in_ready !== (i < used)) begin
                errors++;
                $display("FAIL %s ready byte %0d: got %b want %b", name, i, bus.in_ready, i < used);
            end
            send(img[i]);
            if (i >= 2 && i < 2 + 4 * nw && (i - 2) % 4 == 3) begin
                checks++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'((i - 2) / 4) ||
                    bus.mem_wdata !== {img[i-3], img[i-2], img[i-1], img[i]}) begin
                    errors++;
                    $display("FAIL %s write latency word %0d: got we=%b addr=%0h data=%h want 1 %0h %h", name, (i - 2) / 4,
                             bus.mem_we, bus.mem_addr, bus.mem_wdata, (i - 2) / 4, {img[i-3], img[i-2], img[i-1], img[i]});
                end
            end
            if (i == 1 && n > DEPTH) begin
                checks++;
                if (error !== 1'b1 || bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s header overflow: got error=%b ready=%b want 1 0", name, error, bus.in_ready);
                end
            end
        end
        checks++;
        if (done !== !exp_err || error !== exp_err || (img.size() == used && cpu_rstn !== 1'b0)) begin
            errors++;
            $display("FAIL %s terminal: got done=%b error=%b cpu_rstn=%b want %b %b 0", name, done, error, cpu_rstn, !exp_err, exp_err);
        end
        @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_rstn !== !exp_err || bus.in_ready !== 1'b0 || done !== !exp_err || error !== exp_err) begin
            errors++;
            $display("FAIL %s settled: got cpu_rstn=%b ready=%b done=%b error=%b want %b 0 %b %b",
                     name, cpu_rstn, bus.in_ready, done, error, !exp_err, !exp_err, exp_err);
        end
        checks++;
        if (wa.size() != nw) begin
            errors++;
            $display("FAIL %s write count: got %0d want %0d", name, wa.size(), nw);
        end else
            for (int k = 0; k < nw; k++) begin
                checks++;
                if (wa[k] !== ADDR_W'(k) || wd[k] !== {img[2+4*k], img[3+4*k], img[4+4*k], img[5+4*k]}) begin
                    errors++;
                    $display("FAIL %s write %0d: got addr=%0h data=%h want %0h %h", name, k, wa[k], wd[k], k,
                             {img[2+4*k], img[3+4*k], img[4+4*k], img[5+4*k]});
                end
            end
    endtask
    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_reset_values("after reset");
    endtask
    task automatic test_basic();
        do_reset();
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        seal();
        run_case("basic", 0);
    endtask
    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
            seal();
            run_case("gaps", 5);
        end
    endtask
    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(1, 8);
            do_reset();
            img = '{8'h00, 8'(n)};
            repeat (4 * n) img.push_back(8'($urandom));
            seal();
            run_case("random", r % 2 ? 3 : 0);
        end
    endtask
    task automatic test_full_depth();
        do_reset();
        img = '{8'h00, 8'h80};
        repeat (4 * DEPTH) img.push_back(8'($urandom));
        seal();
        run_case("full depth", 0);
    endtask
    task automatic test_overflow();
        do_reset();
        img = '{8'h00, 8'h81, 8'h11, 8'h22, 8'h33, 8'h44};
        run_case("overflow", 1);
    endtask
    task automatic test_zero();
        do_reset();
        img = '{8'h00, 8'h00};
        seal();
        run_case("zero", 0);
    endtask
`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        run_case("checksum good", 0);
        do_reset();
        img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        run_case("checksum bad", 2);
    endtask
`endif
    task automatic test_reset_mid();
        do_reset();
        img = '{8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        foreach (img[i]) send(img[i]);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_values("mid-load reset");
        rstn = 1'b1;
        @(negedge clk);
        img = '{8'h00, 8'h01, 8'h5A, 8'hC3, 8'h0F, 8'h96};
        seal();
        run_case("reload", 0);
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        test_reset();
        test_basic();
        test_gaps();
        test_random();
        test_full_depth();
        test_overflow();
        test_zero();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_boot_loader.md
# mc_boot_loader

Program loader that sits directly upstream of the multicycle computer. It receives a byte stream over a valid/ready handshake, packs bytes into 32-bit big-endian words, and writes them sequentially into the unified instruction/data memory starting at word 0. It holds the CPU in reset until the image is fully written, then releases it. This replaces file preloading on hardware.

## Interface
- `ADDR_W`, default 7: memory word-address width; memory depth is 2^ADDR_W words.
- `clk` input 1: system clock; all state changes on its rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_byte` is valid this cycle.
- `in_byte` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `mem_we` output 1: one-cycle word write strobe to memory.
- `mem_addr` output ADDR_W: word address of the write.
- `mem_wdata` output 32: word to write.
- `cpu_rstn` output 1: active-low reset driven to the CPU.
- `done` output 1: load completed successfully; sticky until reset.
- `error` output 1: load aborted; sticky until reset.

## Operation
- Stream format: two header bytes forming a 16-bit word count N (MSB first), then N×4 data bytes with each word sent MSB first. With `BOOT_CHECKSUM_EN`, one checksum byte follows the data.
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- States:
  - HDR0: accept the count MSB, then go to HDR1.
  - HDR1: accept the count LSB. At that edge:
    - N=0 goes to CHK (macro on) or DONE (macro off).
    - N>2^ADDR_W goes to ERR.
    - Otherwise go to DATA.
  - DATA: shift each byte into a 32-bit assembly register (`{reg[23:0],byte}`) and keep a 2-bit byte counter.
    - On the 4th byte, register `mem_wdata`/`mem_addr` and pulse `mem_we`.
    - Then increment the word counter (ADDR_W+1 bits; no wrap is possible because N≤depth).
    - After word N−1, go to CHK or DONE.
  - CHK: accept one byte. Match goes to DONE; mismatch goes to ERR.
  - DONE: terminal.
  - ERR: terminal.
- `in_ready` is 1 in HDR0, HDR1, DATA and CHK, and 0 in DONE and ERR. No backpressure is applied mid-image.
- `in_valid` low simply stalls; partial words are held indefinitely.
- `cpu_rstn`:
  - It is registered and equals 1 only while the state is DONE, so it rises one cycle after entering DONE.
  - It stays 0 in ERR.
- Reset mid-load: all state, counters and outputs return to reset values. Memory already written is not cleared. The next load restarts at HDR0.
- Only a reset can start a new load.

## Timing
- Reset values:
  - `in_ready`=1 (HDR0).
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_rstn`=0, `done`=0, `error`=0.
- Write latency: the 4th byte of word k is accepted at edge E. During the cycle after E, `mem_we`=1, `mem_addr`=k and `mem_wdata` holds the word. `mem_we` returns to 0 at edge E+1 unless another word completes.
- Maximum rate: one byte per cycle; one write per 4 cycles.
- For the final word (macro off): DONE is entered at edge E, `done`=1 from E, and `cpu_rstn`=1 from E+1. The last write therefore occurs while the CPU is still in reset.
- `done`/`error` are registered from the state transition edge.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - The CHK state exists and the loader keeps an 8-bit running sum (mod 256) of all data bytes, excluding header bytes.
  - A trailing byte equal to the sum leads to DONE; any other value leads to ERR with `error`=1 and `cpu_rstn` held at 0.
  - N=0 expects checksum 0x00.
- Undefined: there is no CHK state and no checksum byte. DATA or HDR1 (when N=0) goes straight to DONE.

## Test plan
- Reset then stream 00 02 | 12 34 56 78 | 9A BC DE F0, one byte per cycle (macro off). Require `mem_we` pulses with (addr 0, 0x12345678) and (addr 1, 0x9ABCDEF0), `done`=1, and `cpu_rstn` rising one cycle after `done`.
- Same image with `in_valid` deasserted randomly for 0–5 cycles between bytes. Require identical writes, no spurious `mem_we`, and `in_ready` held at 1 throughout.
- ADDR_W=7 with header 00 81 (N=129). Require `error`=1 at the header edge, `in_ready`=0, no `mem_we`, and `cpu_rstn`=0 forever.
- Header 00 00. Require `done`=1 immediately with no writes (macro off), or with `BOOT_CHECKSUM_EN` a required trailing 00 that then gives `done`.
- `BOOT_CHECKSUM_EN`, image 00 01 | 01 02 03 04 with trailing 0A. Require `done`=1. The same image with trailing 0B requires `error`=1 and `cpu_rstn`=0.
- Assert `rstn`=0 after 6 data bytes, then release and send a full 1-word image. Require all outputs at reset values during reset and the new word written at address 0.
